// File: rtl/cla_add_sub_pkg.sv
// cla_add_sub_pkg: shared constants and helpers for the CLA add/sub arbiter
package cla_add_sub_pkg;
  localparam int CLA_DATA_IN_W = 4;
  function automatic int calc_id_w(input int num_req);
    return (num_req <= 1) ? 1 : $clog2(num_req);
  endfunction
  function automatic logic signed_ovf(input logic a_msb, input logic b_eff_msb, input logic sum_msb);
    return (a_msb == b_eff_msb) && (sum_msb != a_msb);
  endfunction
endpackage

// File: rtl/cla_rr_arbiter.sv
// cla_rr_arbiter: round-robin arbiter; pointer moves only on an accepted grant
module cla_rr_arbiter import cla_add_sub_pkg::*; #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W = calc_id_w(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);
  logic [ID_W-1:0] ptr;
  // scan farthest-to-nearest so the nearest requester after ptr wins
  always_comb begin
    grant = '0;
    grant_id = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[(int'(ptr) + i) % NUM_REQ]) begin
        grant = NUM_REQ'(1) << ((int'(ptr) + i) % NUM_REQ);
        grant_id = ID_W'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) ptr <= ID_W'(NUM_REQ - 1);
    else if (advance) ptr <= grant_id;
endmodule

// File: rtl/cla_signed_add_sub.sv
// cla_signed_add_sub: signed adder/subtractor built from 4-bit carry-lookahead groups
module cla_signed_add_sub import cla_add_sub_pkg::*; #(
  parameter int DATA_IN_W = 16
) (
  input  logic [DATA_IN_W-1:0] a_i,
  input  logic [DATA_IN_W-1:0] b_i,
  input  logic                 sub_nadd_i,
  output logic [DATA_IN_W-1:0] out_o,
  output logic                 carry_o,
  output logic                 ovf_o
);
  localparam int NG = DATA_IN_W / CLA_DATA_IN_W;
  logic [DATA_IN_W-1:0] b_eff, p, g;
  assign b_eff = b_i ^ {DATA_IN_W{sub_nadd_i}};
  assign p = a_i ^ b_eff;
  assign g = a_i & b_eff;
  genvar k;
  generate
    for (k = 0; k < NG; k++) begin : grp
      logic ci, co;
      logic [CLA_DATA_IN_W-1:0] gp, gg, c;
      assign gp = p[k*CLA_DATA_IN_W +: CLA_DATA_IN_W];
      assign gg = g[k*CLA_DATA_IN_W +: CLA_DATA_IN_W];
      // groups ripple into each other; the +1 of two's-complement subtract enters as the first carry
      if (k == 0) begin : first
        assign ci = sub_nadd_i;
      end else begin : chain
        assign ci = grp[k-1].co;
      end
      assign c[0] = ci;
      assign c[1] = gg[0] | (gp[0] & ci);
      assign c[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
      assign c[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & ci);
      assign co = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]) | ((&gp) & ci);
      assign out_o[k*CLA_DATA_IN_W +: CLA_DATA_IN_W] = gp ^ c;
    end
  endgenerate
  assign carry_o = grp[NG-1].co;
  assign ovf_o = signed_ovf(a_i[DATA_IN_W-1], b_eff[DATA_IN_W-1], out_o[DATA_IN_W-1]);
endmodule

// File: rtl/cla_add_sub_arbiter.sv
// cla_add_sub_arbiter: round-robin shared CLA add/sub with a 2-stage valid/ready pipeline
module cla_add_sub_arbiter import cla_add_sub_pkg::*; #(
  parameter  int DATA_IN_W = 16,
  parameter  int NUM_REQ = 4,
  localparam int ID_W = calc_id_w(NUM_REQ)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [NUM_REQ-1:0]           req_sub_nadd_i,
  input  logic [NUM_REQ*DATA_IN_W-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_IN_W-1:0] req_b_i,
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic [ID_W-1:0]              res_id_o,
  output logic [DATA_IN_W-1:0]         res_data_o,
  output logic                         res_carry_o,
  output logic                         res_ovf_o
);
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0] grant_id, s1_id;
  logic [DATA_IN_W-1:0] s1_a, s1_b, sum;
  logic s1_sub, s1_valid, s2_valid, s1_adv, can_accept, accept, sum_carry, sum_ovf;
  assign s1_adv = s1_valid & (!s2_valid | res_ready_i);
  assign can_accept = !s1_valid | s1_adv;
  assign req_ready_o = grant & {NUM_REQ{can_accept & !rst_i}};
  assign accept = |(req_ready_o & req_valid_i);
  assign res_valid_o = s2_valid;
  cla_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk_i(clk_i), .rst_i(rst_i), .req(req_valid_i), .advance(accept),
    .grant(grant), .grant_id(grant_id)
  );
  cla_signed_add_sub #(.DATA_IN_W(DATA_IN_W)) u_alu (
    .a_i(s1_a), .b_i(s1_b), .sub_nadd_i(s1_sub),
    .out_o(sum), .carry_o(sum_carry), .ovf_o(sum_ovf)
  );
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      s1_a <= '0;
      s1_b <= '0;
      s1_sub <= 1'b0;
      s1_id <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      res_data_o <= '0;
      res_id_o <= '0;
      res_carry_o <= 1'b0;
      res_ovf_o <= 1'b0;
    end else begin
      if (accept) begin
        s1_a <= req_a_i[int'(grant_id)*DATA_IN_W +: DATA_IN_W];
        s1_b <= req_b_i[int'(grant_id)*DATA_IN_W +: DATA_IN_W];
        s1_sub <= req_sub_nadd_i[grant_id];
        s1_id <= grant_id;
      end
      s1_valid <= accept | (s1_valid & !s1_adv);
      if (s1_adv) begin
        res_data_o <= sum;
        res_carry_o <= sum_carry;
        res_ovf_o <= sum_ovf;
        res_id_o <= s1_id;
      end
      s2_valid <= s1_adv | (s2_valid & !res_ready_i);
    end
endmodule

// File: tb/tb_cla_add_sub_arbiter.sv
// tb_cla_add_sub_arbiter: directed and random checks against a queue-based reference model
module tb_cla_add_sub_arbiter;
  localparam int W = 16;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_valid, req_ready, req_sub;
  logic [N*W-1:0] req_a, req_b;
  logic res_valid, res_ready, res_carry, res_ovf;
  logic [1:0] res_id;
  logic [W-1:0] res_data, held;
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic sub;
    int id;
    int acc;
  } op_t;
  op_t q[$];
  int checks = 0;
  int failures = 0;
  int ptr = N - 1;
  int cyc = 0;
  int obs_gid = -1;
  bit refill = 1'b0;

  always #5 clk = ~clk;

  cla_add_sub_arbiter #(.DATA_IN_W(W), .NUM_REQ(N)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_sub_nadd_i(req_sub), .req_a_i(req_a), .req_b_i(req_b),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_id_o(res_id),
    .res_data_o(res_data), .res_carry_o(res_carry), .res_ovf_o(res_ovf)
  );

  // {carry, ovf, data} from integer arithmetic
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    int sa, sb, r;
    logic c, ov;
    logic [31:0] rv;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = sub ? sa - sb : sa + sb;
    c = sub ? (a >= b) : ((int'(a) + int'(b)) > 65535);
    ov = (r > 32767) || (r < -32768);
    rv = r;
    return {c, ov, rv[W-1:0]};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'h0000;
      3: return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int r, input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[r] = 1'b1;
    req_sub[r] = sub;
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
  endtask

  task automatic new_op(input int r);
    set_op(r, 1'($urandom % 2), pick(), pick());
  endtask

  // called at edge+1 with inputs driven; checks, then advances past the next edge
  task automatic tick();
    int g;
    bit full, ev;
    logic [N-1:0] m;
    #1;
    full = (q.size() == 2) && !res_ready;
    g = -1;
    for (int i = 1; i <= N; i++)
      if (g < 0 && req_valid[(ptr + i) % N]) g = (ptr + i) % N;
    m = (full || g < 0) ? '0 : N'(1) << g;
    chk("ready", 32'(req_ready), 32'(m));
    ev = (q.size() > 0) && (q[0].acc < cyc - 1);
    chk("res_valid", 32'(res_valid), 32'(ev));
    if (ev) begin
      chk("res_result", 32'({res_carry, res_ovf, res_data}), 32'(model(q[0].a, q[0].b, q[0].sub)));
      chk("res_id", 32'(res_id), 32'(q[0].id));
    end
    obs_gid = -1;
    for (int r = 0; r < N; r++) if (req_ready[r]) obs_gid = r;
    if (ev && res_ready) void'(q.pop_front());
    if (m != '0) begin
      q.push_back('{a: req_a[g*W +: W], b: req_b[g*W +: W], sub: req_sub[g], id: g, acc: cyc});
      ptr = g;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (m != '0) begin
      if (refill) new_op(g);
      else req_valid[g] = 1'b0;
    end
  endtask

  task automatic single(input int r, input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ed, input logic ec, input logic eo);
    res_ready = 1'b1;
    set_op(r, sub, a, b);
    tick();
    chk("single_grant", 32'(obs_gid), 32'(r));
    tick();
    chk("single_valid", 32'(res_valid), 32'd1);
    chk("single_data", 32'(res_data), 32'(ed));
    chk("single_carry", 32'(res_carry), 32'(ec));
    chk("single_ovf", 32'(res_ovf), 32'(eo));
    chk("single_id", 32'(res_id), 32'(r));
  endtask

  initial begin
    req_valid = '1;
    req_sub = '0;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b1;
    #12;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_outputs", 32'({res_carry, res_ovf, res_id, res_data}), 32'd0);
    req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    single(0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    single(2, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
    single(2, 1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0);
    single(2, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);
    single(3, 1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0);

    refill = 1'b1;
    for (int r = 0; r < N; r++) new_op(r);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("fair_grant", 32'(obs_gid), 32'(i % N));
      if (i >= 1) chk("no_bubble", 32'(res_valid), 32'd1);
    end
    refill = 1'b0;
    req_valid = '0;
    repeat (3) tick();

    single(0, 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0);
    tick();
    res_ready = 1'b0;
    set_op(1, 1'b0, 16'h4000, 16'h4000);
    set_op(3, 1'b1, 16'h0100, 16'h0001);
    tick();
    chk("bp_grant1", 32'(obs_gid), 32'd1);
    tick();
    chk("bp_grant3", 32'(obs_gid), 32'd3);
    held = res_data;
    set_op(0, 1'b0, 16'hFFFF, 16'h0001);
    repeat (5) begin
      tick();
      chk("bp_no_ready", 32'(obs_gid), 32'hFFFF_FFFF);
      chk("bp_hold_id", 32'(res_id), 32'd1);
      chk("bp_hold_data", 32'(res_data), 32'(held));
    end
    res_ready = 1'b1;
    tick();
    chk("bp_same_edge_grant", 32'(obs_gid), 32'd0);
    chk("bp_drain_id3", 32'(res_id), 32'd3);
    tick();
    chk("bp_drain_id0", 32'(res_id), 32'd0);
    tick();

    res_ready = 1'b0;
    set_op(1, 1'b0, 16'h0001, 16'h0002);
    set_op(2, 1'b0, 16'h0003, 16'h0004);
    tick();
    tick();
    set_op(1, 1'b0, 16'h0001, 16'h0001);
    set_op(2, 1'b0, 16'h0002, 16'h0002);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(res_valid), 32'd0);
    chk("rst_async_ready", 32'(req_ready), 32'd0);
    q.delete();
    ptr = N - 1;
    @(posedge clk);
    #1;
    chk("rst_hold_ready", 32'(req_ready), 32'd0);
    chk("rst_hold_data", 32'(res_data), 32'd0);
    req_valid = '0;
    set_op(0, 1'b0, 16'h0010, 16'h0020);
    set_op(2, 1'b1, 16'h0030, 16'h0040);
    rst = 1'b0;
    res_ready = 1'b1;
    tick();
    chk("rst_restart_grant", 32'(obs_gid), 32'd0);
    tick();
    chk("rst_next_grant", 32'(obs_gid), 32'd2);
    repeat (3) tick();
    set_op(0, 1'b0, 16'h0101, 16'h0202);
    set_op(3, 1'b1, 16'h0303, 16'h0404);
    tick();
    chk("idle_hold_grant", 32'(obs_gid), 32'd3);
    tick();
    chk("idle_next_grant", 32'(obs_gid), 32'd0);

    repeat (400) begin
      for (int r = 0; r < N; r++) if (!req_valid[r] && ($urandom % 3) == 0) new_op(r);
      res_ready = ($urandom % 4) != 0;
      tick();
    end
    req_valid = '0;
    res_ready = 1'b1;
    repeat (4) tick();
    chk("final_empty", 32'(res_valid), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
